// File: rtl/hc595_pkg.sv
// hc595_pkg: shared types, defaults and sizing helpers for the 74HC595
// chain driver and its phase timer.
package hc595_pkg;

  // Default chain shape and timing: two ICs (segment byte + digit-select
  // byte), one clk per SCLK half-period, one clk of latch pulse.
  localparam int DEFAULT_NUM_ICS      = 2;
  localparam int DEFAULT_CLK_DIV      = 1;
  localparam int DEFAULT_LATCH_CYCLES = 1;

  // Driver FSM state encoding. Plain 2-bit constants keep the encoding
  // visible to older tools and to anyone probing the state in a waveform.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_SHIFT_LO = 2'd1;
  localparam state_t ST_SHIFT_HI = 2'd2;
  localparam state_t ST_LATCH    = 2'd3;

  // Width of the parallel word: eight bits per chained 595.
  function automatic int word_width(input int num_ics);
    return 8 * num_ics;
  endfunction

  // The phase timer is reloaded with either the SCLK half-period or the
  // latch width, so it must hold the larger of the two.
  function automatic int phase_cnt_width(input int clk_div, input int latch_cycles);
    int longest;
    longest = (clk_div > latch_cycles) ? clk_div : latch_cycles;
    return $clog2(longest + 1);
  endfunction

  // Bit counter only needs to reach W-1.
  function automatic int bit_cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/hc595_phase_timer.sv
// hc595_phase_timer: loadable down-counter used to time each FSM phase.
// Loading value N makes o_tick assert on the N-th cycle after the load,
// i.e. on the last cycle the FSM should spend in the phase.
module hc595_phase_timer
  import hc595_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_count;

  // Reload on every phase entry; otherwise count down and rest at zero
  // so the timer stays quiet while the driver is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_tick = (r_count == WIDTH'(1));

endmodule

// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver: shifts a parallel word into a daisy-chain of
// 74HC595s (SCLK/DATA/LATCH) and hands back a busy/done handshake so the
// display scanner only moves on once a frame has been latched.
//
// Build option: define HC595_LSB_FIRST_EN to send data_i[0] first
// (shift register moves right). Default build sends data_i[W-1] first.
module hc595_chain_driver
  import hc595_pkg::*;
#(
  parameter int NUM_ICS      = DEFAULT_NUM_ICS,
  parameter int CLK_DIV      = DEFAULT_CLK_DIV,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              trigger_i,
  input  logic [word_width(NUM_ICS)-1:0]    data_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              sclk_o,
  output logic                              data_o,
  output logic                              latch_en_o
);

  localparam int W  = word_width(NUM_ICS);
  localparam int PW = phase_cnt_width(CLK_DIV, LATCH_CYCLES);
  localparam int BW = bit_cnt_width(W);

  localparam logic [PW-1:0] SHIFT_LOAD = PW'(CLK_DIV);
  localparam logic [PW-1:0] LATCH_LOAD = PW'(LATCH_CYCLES);
  localparam logic [BW-1:0] LAST_BIT   = BW'(W - 1);

  state_t          r_state;
  logic [W-1:0]    r_shreg;
  logic [BW-1:0]   r_bit_cnt;
  logic            r_sclk;
  logic            r_data;
  logic            r_latch;
  logic            r_busy;
  logic            r_done;

  state_t          w_next_state;
  logic            w_tick;
  logic            w_load;
  logic [PW-1:0]   w_load_val;
  logic            w_accept;
  logic            w_rise;
  logic            w_fall;
  logic            w_last_bit;
  logic            w_advance;
  logic            w_to_latch;
  logic            w_finish;
  logic            w_first_bit;
  logic            w_next_bit;
  logic [W-1:0]    w_shifted;

  hc595_phase_timer #(
    .WIDTH (PW)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tick     (w_tick)
  );

  // Bit ordering: which input bit leaves first, which bit follows the
  // current one, and how the shift register moves between bits.
`ifdef HC595_LSB_FIRST_EN
  assign w_first_bit = data_i[0];
  assign w_next_bit  = r_shreg[1];
  assign w_shifted   = r_shreg >> 1;
`else
  assign w_first_bit = data_i[W-1];
  assign w_next_bit  = r_shreg[W-2];
  assign w_shifted   = r_shreg << 1;
`endif

  // Decode the handful of events that move the transfer along; every
  // register below is written only in terms of these.
  always_comb begin
    w_accept   = (r_state == ST_IDLE) && trigger_i;
    w_rise     = (r_state == ST_SHIFT_LO) && w_tick;
    w_fall     = (r_state == ST_SHIFT_HI) && w_tick;
    w_last_bit = (r_bit_cnt == LAST_BIT);
    w_advance  = w_fall && !w_last_bit;
    w_to_latch = w_fall && w_last_bit;
    w_finish   = (r_state == ST_LATCH) && w_tick;
  end

  // Next state plus the phase-timer reload: every state entry except the
  // return to IDLE restarts the timer with that phase's length.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = SHIFT_LOAD;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_SHIFT_LO;
          w_load       = 1'b1;
        end
      end
      ST_SHIFT_LO: begin
        if (w_rise) begin
          w_next_state = ST_SHIFT_HI;
          w_load       = 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (w_advance) begin
          w_next_state = ST_SHIFT_LO;
          w_load       = 1'b1;
        end else if (w_to_latch) begin
          w_next_state = ST_LATCH;
          w_load       = 1'b1;
          w_load_val   = LATCH_LOAD;
        end
      end
      ST_LATCH: begin
        if (w_finish) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Word capture and per-bit shifting; only the accept edge looks at
  // data_i, so input changes mid-transfer are harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shreg   <= data_i;
      r_bit_cnt <= '0;
    end else if (w_advance) begin
      r_shreg   <= w_shifted;
      r_bit_cnt <= r_bit_cnt + BW'(1);
    end
  end

  // SCLK is high exactly while in SHIFT_HI.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk <= 1'b0;
    end else if (w_rise) begin
      r_sclk <= 1'b1;
    end else if (w_fall) begin
      r_sclk <= 1'b0;
    end
  end

  // Serial data changes only with the falling SCLK (or at accept), holds
  // the last bit through the latch pulse, then parks at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= 1'b0;
    end else if (w_accept) begin
      r_data <= w_first_bit;
    end else if (w_advance) begin
      r_data <= w_next_bit;
    end else if (w_finish) begin
      r_data <= 1'b0;
    end
  end

  // Latch pulse covers the whole LATCH phase; a reset mid-transfer never
  // reaches it, so the 595 outputs keep the previous frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch <= 1'b0;
    end else if (w_to_latch) begin
      r_latch <= 1'b1;
    end else if (w_finish) begin
      r_latch <= 1'b0;
    end
  end

  // Busy spans from the accept edge to the end of the latch pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
    end else if (w_accept) begin
      r_busy <= 1'b1;
    end else if (w_finish) begin
      r_busy <= 1'b0;
    end
  end

  // Done is a single-cycle strobe on the first non-busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign sclk_o     = r_sclk;
  assign data_o     = r_data;
  assign latch_en_o = r_latch;

endmodule

// File: tb/tb_hc595_chain_driver.sv
// tb_hc595_chain_driver: drives a default chain (2 ICs) and a wider,
// slower chain (3 ICs, CLK_DIV=3, LATCH_CYCLES=2) and compares every
// output cycle against a frame-timing model, plus a 595 shift/latch model.
module tb_hc595_chain_driver;

  localparam int W1 = 16;
  localparam int N1 = 1;
  localparam int L1 = 1;
  localparam int T1 = 2 * N1 * W1 + L1;
  localparam int W2 = 24;
  localparam int N2 = 3;
  localparam int L2 = 2;
  localparam int T2 = 2 * N2 * W2 + L2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trig1 = 1'b0;
  logic        trig2 = 1'b0;
  logic [15:0] data1 = '0;
  logic [23:0] data2 = '0;
  logic        busy1, done1, sclk1, dout1, latch1;
  logic        busy2, done2, sclk2, dout2, latch2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hc595_chain_driver dut1 (
    .clk        (clk),
    .reset      (reset),
    .trigger_i  (trig1),
    .data_i     (data1),
    .busy_o     (busy1),
    .done_o     (done1),
    .sclk_o     (sclk1),
    .data_o     (dout1),
    .latch_en_o (latch1)
  );

  hc595_chain_driver #(
    .NUM_ICS      (3),
    .CLK_DIV      (N2),
    .LATCH_CYCLES (L2)
  ) dut2 (
    .clk        (clk),
    .reset      (reset),
    .trigger_i  (trig2),
    .data_i     (data2),
    .busy_o     (busy2),
    .done_o     (done2),
    .sclk_o     (sclk2),
    .data_o     (dout2),
    .latch_en_o (latch2)
  );

  // Position in the input word of the b-th bit sent on the wire.
  function automatic int bitPos(input int b, input int w);
`ifdef HC595_LSB_FIRST_EN
    return b;
`else
    return w - 1 - b;
`endif
  endfunction

  // Expected {busy, done, sclk, data, latch} mk cycles after the accept edge.
  function automatic logic [4:0] expOut(input int mk, input logic [23:0] word,
                                        input int n, input int l, input int w);
    logic [4:0] r;
    int t;
    int j;
    r = '0;
    t = 2 * n * w + l;
    if (mk >= 1 && mk <= t) begin
      r[4] = 1'b1;
      if (mk <= 2 * n * w) begin
        j = mk - 1;
        r[2] = ((j % (2 * n)) >= n);
        r[1] = word[bitPos(j / (2 * n), w)];
      end else begin
        r[0] = 1'b1;
        r[1] = word[bitPos(w - 1, w)];
      end
    end else if (mk == t + 1) begin
      r[3] = 1'b1;
    end
    return r;
  endfunction

  // What a 595 chain shows after latching a frame of word: the b-th bit
  // sent ends up b places below the top of the chain.
  function automatic logic [23:0] latchedWord(input logic [23:0] word, input int w);
    logic [23:0] r;
    r = '0;
    for (int b = 0; b < w; b++) r[w - 1 - b] = word[bitPos(b, w)];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Frame-position model: 0 = idle, else cycles since the accept edge.
  int          mk1 = 0;
  int          mk2 = 0;
  logic [23:0] word1 = '0;
  logic [23:0] word2 = '0;

  always @(posedge clk) begin
    if (reset) begin
      mk1 = 0;
      mk2 = 0;
    end else begin
      if (mk1 == 0 || mk1 == T1 + 1) begin
        if (trig1) begin mk1 = 1; word1 = {8'h00, data1}; end
        else mk1 = 0;
      end else mk1 = mk1 + 1;
      if (mk2 == 0 || mk2 == T2 + 1) begin
        if (trig2) begin mk2 = 1; word2 = data2; end
        else mk2 = 0;
      end else mk2 = mk2 + 1;
    end
  end

  // 595 chain models and pulse-width measurements.
  logic [15:0] sr1 = '0, par1 = '0;
  logic [23:0] sr2 = '0, par2 = '0;
  logic prevSclk1 = 0, prevLatch1 = 0, prevBusy1 = 0;
  logic prevSclk2 = 0, prevLatch2 = 0, prevBusy2 = 0;
  int rises1 = 0, latchRises1 = 0, latchRun1 = 0, latchLen1 = 0, busyRun1 = 0, busyLen1 = 0;
  int rises2 = 0, latchRun2 = 0, latchLen2 = 0, busyRun2 = 0, busyLen2 = 0;
  int hiRun2 = 0, loRun2 = 0, hiMin2 = 999, hiMax2 = 0, loMin2 = 999, loMax2 = 0;
  int cyc = 0, lastRise1 = 0, period1 = 0;

  always @(negedge clk) begin
    cyc++;
    checkOutput("dut1_outputs", {27'd0, busy1, done1, sclk1, dout1, latch1}, {27'd0, expOut(mk1, word1, N1, L1, W1)});
    checkOutput("dut2_outputs", {27'd0, busy2, done2, sclk2, dout2, latch2}, {27'd0, expOut(mk2, word2, N2, L2, W2)});

    if (sclk1 && !prevSclk1) begin sr1 = {sr1[14:0], dout1}; rises1++; end
    if (latch1 && !prevLatch1) begin par1 = sr1; latchRises1++; end
    if (latch1) latchRun1++; else if (prevLatch1) begin latchLen1 = latchRun1; latchRun1 = 0; end
    if (busy1) busyRun1++; else if (prevBusy1) begin busyLen1 = busyRun1; busyRun1 = 0; end
    if (busy1 && !prevBusy1) begin period1 = cyc - lastRise1; lastRise1 = cyc; end

    if (sclk2 && !prevSclk2) begin
      sr2 = {sr2[22:0], dout2};
      rises2++;
      if (loRun2 < loMin2) loMin2 = loRun2;
      if (loRun2 > loMax2) loMax2 = loRun2;
      loRun2 = 0;
    end
    if (busy2 && !sclk2 && !latch2) loRun2++;
    if (sclk2) hiRun2++;
    else if (prevSclk2) begin
      if (hiRun2 < hiMin2) hiMin2 = hiRun2;
      if (hiRun2 > hiMax2) hiMax2 = hiRun2;
      hiRun2 = 0;
    end
    if (latch2 && !prevLatch2) par2 = sr2;
    if (latch2) latchRun2++; else if (prevLatch2) begin latchLen2 = latchRun2; latchRun2 = 0; end
    if (busy2) busyRun2++; else if (prevBusy2) begin busyLen2 = busyRun2; busyRun2 = 0; end

    prevSclk1 = sclk1; prevLatch1 = latch1; prevBusy1 = busy1;
    prevSclk2 = sclk2; prevLatch2 = latch2; prevBusy2 = busy2;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic t, input logic [15:0] d);
    trig1 = t;
    data1 = d;
    tick();
  endtask

  task automatic waitDone1(input int maxc, input string name);
    int k;
    k = 0;
    while (!done1 && k < maxc) begin tick(); k++; end
    checkOutput({name, "_done_seen"}, {31'd0, done1}, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] d;
    logic [15:0] words [2];
    logic [15:0] parBefore;
    int k;

    // Reset held with triggers asserted: nothing may start.
    reset = 1'b1; trig1 = 1'b1; trig2 = 1'b1; data1 = 16'hBEEF; data2 = 24'h123456;
    repeat (3) tick();
    checkOutput("reset_busy1", {31'd0, busy1}, 32'd0);
    checkOutput("reset_busy2", {31'd0, busy2}, 32'd0);
    checkOutput("reset_sclk_edges", rises1 + rises2, 32'd0);
    reset = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
    repeat (2) tick();
    checkOutput("idle_after_reset_busy", {31'd0, busy1}, 32'd0);

    // Single frame with hand-computed expectations.
    rises1 = 0; latchRises1 = 0;
    applyStimulus(1'b1, 16'hA53C);
    trig1 = 1'b0;
    waitDone1(60, "single");
`ifdef HC595_LSB_FIRST_EN
    checkOutput("single_latched", {16'd0, par1}, 32'h3CA5);
`else
    checkOutput("single_latched", {16'd0, par1}, 32'hA53C);
`endif
    checkOutput("single_sclk_edges", rises1, 32'd16);
    checkOutput("single_latch_pulses", latchRises1, 32'd1);
    checkOutput("single_latch_width", latchLen1, 32'd1);
    checkOutput("single_busy_len", busyLen1, 32'd33);
    tick();
    checkOutput("single_done_width", {31'd0, done1}, 32'd0);

    // Second trigger while busy must be ignored.
    rises1 = 0;
    applyStimulus(1'b1, 16'h5A0F);
    trig1 = 1'b0;
    repeat (4) tick();
    applyStimulus(1'b1, 16'hFFFF);
    trig1 = 1'b0;
    waitDone1(60, "ignore");
    checkOutput("ignore_latched", {16'd0, par1}, {8'd0, latchedWord(24'h005A0F, W1)});
    checkOutput("ignore_sclk_edges", rises1, 32'd16);
    repeat (3) tick();
    checkOutput("ignore_no_second_frame", {31'd0, busy1}, 32'd0);

    // Trigger held high: back-to-back frames with alternating data.
    words[0] = 16'h1234; words[1] = 16'hFEDC;
    applyStimulus(1'b1, words[0]);
    for (int f = 0; f < 4; f++) begin
      data1 = words[(f + 1) % 2];
      waitDone1(40, "b2b");
      checkOutput("b2b_latched", {16'd0, par1}, {8'd0, latchedWord({8'd0, words[f % 2]}, W1)});
      if (f > 0) checkOutput("b2b_period", period1, 32'd34);
      if (f == 3) trig1 = 1'b0;
      tick();
    end

    // Reset after 7 SCLK edges: no latch, 595 output untouched.
    parBefore = par1;
    rises1 = 0; latchRises1 = 0;
    applyStimulus(1'b1, 16'($urandom));
    trig1 = 1'b0;
    k = 0;
    while (rises1 < 7 && k < 40) begin tick(); k++; end
    checkOutput("mid_rises", rises1, 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_outputs_zero", {27'd0, busy1, done1, sclk1, dout1, latch1}, 32'd0);
    repeat (3) tick();
    checkOutput("mid_no_latch", latchRises1, 32'd0);
    checkOutput("mid_parallel_kept", {16'd0, par1}, {16'd0, parBefore});
    applyStimulus(1'b1, 16'h00FF);
    trig1 = 1'b0;
    waitDone1(60, "after_reset");
    checkOutput("after_reset_latched", {16'd0, par1}, {8'd0, latchedWord(24'h0000FF, W1)});

    // Random frames with random noise on trigger while busy.
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(1'b1, d);
      for (int c = 0; c < 10; c++) applyStimulus(1'($urandom), 16'($urandom));
      trig1 = 1'b0;
      waitDone1(60, "random");
      checkOutput("random_latched", {16'd0, par1}, {8'd0, latchedWord({8'd0, d}, W1)});
    end

    // Wide, slow chain.
    rises2 = 0;
    data2 = 24'hC0FFEE; trig2 = 1'b1;
    tick();
    trig2 = 1'b0;
    k = 0;
    while (!done2 && k < 200) begin tick(); k++; end
    checkOutput("wide_done_seen", {31'd0, done2}, 32'd1);
    checkOutput("wide_busy_len", busyLen2, 32'd146);
    checkOutput("wide_sclk_edges", rises2, 32'd24);
    checkOutput("wide_hi_min", hiMin2, 32'd3);
    checkOutput("wide_hi_max", hiMax2, 32'd3);
    checkOutput("wide_lo_min", loMin2, 32'd3);
    checkOutput("wide_lo_max", loMax2, 32'd3);
    checkOutput("wide_latch_width", latchLen2, 32'd2);
`ifdef HC595_LSB_FIRST_EN
    checkOutput("wide_latched", {8'd0, par2}, 32'h77FF03);
`else
    checkOutput("wide_latched", {8'd0, par2}, 32'hC0FFEE);
`endif
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
